// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-buffer constants and arbiter grant type
package fb_pkg;

  localparam int DEF_IMG_W = 180;
  localparam int DEF_IMG_H = 180;
  localparam int FRAME_PIX = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR
  } gnt_t;

endpackage

// File: rtl/fb_wfifo.sv
// rtl/fb_wfifo.sv - small synchronous write FIFO with flush
module fb_wfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still fits when the same cycle frees a slot
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush keeps only a coincident push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      count  <= CW'(push);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; a push during flush lands in slot 0
  always_ff @(posedge clk) begin
    if (flush) begin
      if (push) mem[0] <= din;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/frame_buf_arbiter.sv
// rtl/frame_buf_arbiter.sv - read-priority RAM arbiter and frame write sequencer (option: FB_ARB_STATS_EN)
module frame_buf_arbiter import fb_pkg::*; #(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic              board_clk,
  input  logic              sys_rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              sof_clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              frame_done,
  output logic              frame_valid,
  output logic              wr_ovf
`ifdef FB_ARB_STATS_EN
  ,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(WFIFO_DEPTH):0]  max_fill
`endif
);

  localparam int FRAME_LAST = IMG_W * IMG_H - 1;
  localparam int CW         = $clog2(WFIFO_DEPTH) + 1;

  gnt_t              gnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              last_pix;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              drop;

  fb_wfifo #(
    .DEPTH (WFIFO_DEPTH),
    .W     (DATA_W)
  ) u_wfifo (
    .clk   (board_clk),
    .rst   (sys_rst),
    .flush (sof_clr),
    .push  (wr_req),
    .din   (wr_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // One decision per cycle: reads win; a frame restart cancels any write slot
  always_comb begin
    gnt = GNT_IDLE;
    if (rd_req) begin
      gnt = GNT_RD;
    end else if (!fifo_empty && !sof_clr) begin
      gnt = GNT_WR;
    end
  end

  assign fifo_pop = (gnt == GNT_WR);
  assign last_pix = (wr_addr == ADDR_W'(FRAME_LAST));
  assign drop     = wr_req && fifo_full && !fifo_pop && !sof_clr;
  assign rd_data  = rd_valid ? ram_rdata : '0;

  // Register the granted access onto the RAM port one cycle after the decision
  always_ff @(posedge board_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_valid  <= 1'b0;
    end else begin
      ram_en   <= (gnt != GNT_IDLE);
      ram_we   <= (gnt == GNT_WR);
      rd_valid <= ram_en && !ram_we;
      unique case (gnt)
        GNT_RD: ram_addr <= rd_addr;
        GNT_WR: begin
          ram_addr  <= wr_addr;
          ram_wdata <= fifo_dout;
        end
        default: ;
      endcase
    end
  end

  // Frame write pointer: advances per granted write, wraps after the last pixel
  always_ff @(posedge board_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_addr <= '0;
    end else if (sof_clr) begin
      wr_addr <= '0;
    end else if (gnt == GNT_WR) begin
      wr_addr <= last_pix ? '0 : wr_addr + ADDR_W'(1);
    end
  end

  // Frame completion pulse aligned with the last write, plus sticky status flags
  always_ff @(posedge board_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_done  <= 1'b0;
      frame_valid <= 1'b0;
      wr_ovf      <= 1'b0;
    end else begin
      frame_done <= (gnt == GNT_WR) && last_pix;
      if ((gnt == GNT_WR) && last_pix) frame_valid <= 1'b1;
      if (drop) wr_ovf <= 1'b1;
    end
  end

`ifdef FB_ARB_STATS_EN
  // Saturating drop counter (restarted with the frame) and FIFO high-water mark
  always_ff @(posedge board_clk or posedge sys_rst) begin
    if (sys_rst) begin
      drop_cnt <= '0;
      max_fill <= '0;
    end else begin
      if (sof_clr) begin
        drop_cnt <= '0;
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (fifo_count > max_fill) max_fill <= fifo_count;
    end
  end
`else
  logic unused_fill;
  assign unused_fill = ^fifo_count;
`endif

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// tb/tb_frame_buf_arbiter.sv - self-checking bench for frame_buf_arbiter
module tb_frame_buf_arbiter;

  logic        board_clk = 1'b0;
  logic        sys_rst;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        sof_clr;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic        frame_done;
  logic        frame_valid;
  logic        wr_ovf;
`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt;
  logic [2:0]  max_fill;
`endif

  frame_buf_arbiter #(
    .IMG_W       (180),
    .IMG_H       (180),
    .ADDR_W      (15),
    .DATA_W      (8),
    .WFIFO_DEPTH (4)
  ) dut (
    .board_clk   (board_clk),
    .sys_rst     (sys_rst),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .sof_clr     (sof_clr),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .frame_done  (frame_done),
    .frame_valid (frame_valid),
    .wr_ovf      (wr_ovf)
`ifdef FB_ARB_STATS_EN
    ,
    .drop_cnt    (drop_cnt),
    .max_fill    (max_fill)
`endif
  );

  always #5 board_clk = ~board_clk;

  int cyc_n = 0;
  always @(posedge board_clk) cyc_n <= cyc_n + 1;

  // RAM read model: contents are a fixed function of the address
  always @(posedge board_clk) begin
    if (ram_en && !ram_we) ram_rdata <= ram_addr[7:0] ^ 8'hA5;
  end

  typedef struct {
    int          cyc;
    logic [14:0] addr;
    logic [7:0]  data;
  } wr_ev_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_ev_t;

  wr_ev_t      wq[$];
  rd_ev_t      rq[$];
  int          fd_cnt = 0;
  logic [14:0] fd_addr = '0;
  logic        fd_we = 1'b0;

  always @(negedge board_clk) begin
    if (ram_en && ram_we) wq.push_back('{cyc_n, ram_addr, ram_wdata});
    if (rd_valid) rq.push_back('{cyc_n, rd_data});
    if (frame_done) begin
      fd_cnt  = fd_cnt + 1;
      fd_addr = ram_addr;
      fd_we   = ram_we;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [14:0] addr,
                        input logic [7:0] data, input int cyc);
    if (idx >= wq.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: write #%0d missing, got %0d writes", name, idx, wq.size());
    end else begin
      chk({name, "_addr"}, 32'(wq[idx].addr), 32'(addr));
      chk({name, "_data"}, 32'(wq[idx].data), 32'(data));
      if (cyc >= 0) chk({name, "_cyc"}, wq[idx].cyc, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic pulse_sof();
    sof_clr = 1'b1;
    step();
    sof_clr = 1'b0;
    step(2);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [14:0] addr;
  } wvec_t;

  wvec_t       vecs[5];
  int          w0;
  int          r0;
  int          t0;
  int          fd0;
  logic [14:0] a;

  initial begin
    vecs[0] = '{8'h11, 15'd0};
    vecs[1] = '{8'h12, 15'd1};
    vecs[2] = '{8'h13, 15'd2};
    vecs[3] = '{8'h14, 15'd3};
    vecs[4] = '{8'h15, 15'd4};

    sys_rst = 1'b1;
    wr_req  = 1'b0;
    wr_data = 8'h00;
    sof_clr = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
    step(3);
    sys_rst = 1'b0;
    step();

    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_wr_ovf", 32'(wr_ovf), 0);
`ifdef FB_ARB_STATS_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_max_fill", 32'(max_fill), 0);
`endif

    // Spaced single bytes, no reads: each written 2 cycles after its request
    w0 = wq.size();
    for (int i = 0; i < 5; i++) begin
      wr_req  = 1'b1;
      wr_data = vecs[i].data;
      t0      = cyc_n;
      step();
      wr_req  = 1'b0;
      step(3);
      chk_wr("t1_wr", w0 + i, vecs[i].addr, vecs[i].data, t0 + 2);
    end

    // Fill the rest of the frame; frame_done only on the last address
    w0  = wq.size();
    fd0 = fd_cnt;
    for (int i = 0; i < 32394; i++) begin
      wr_req  = 1'b1;
      wr_data = 8'(i);
      step();
    end
    wr_req = 1'b0;
    step(4);
    chk("t2_writes", wq.size() - w0, 32394);
    chk("t2_no_early_done", fd_cnt - fd0, 0);
    chk("t2_fv_early", 32'(frame_valid), 0);
    chk_wr("t2_pen", w0 + 32393, 15'd32398, 8'(32393), -1);
    wr_req  = 1'b1;
    wr_data = 8'h99;
    step();
    wr_req  = 1'b0;
    step(4);
    chk("t2_done_cnt", fd_cnt - fd0, 1);
    chk("t2_done_addr", 32'(fd_addr), 32399);
    chk("t2_done_we", 32'(fd_we), 1);
    chk("t2_fv", 32'(frame_valid), 1);
    chk_wr("t2_last", w0 + 32394, 15'd32399, 8'h99, -1);
    wr_req  = 1'b1;
    wr_data = 8'h77;
    step();
    wr_req  = 1'b0;
    step(4);
    chk_wr("t2_wrap", w0 + 32395, 15'd0, 8'h77, -1);
    chk("t2_done_once", fd_cnt - fd0, 1);
    chk("t2_no_ovf", 32'(wr_ovf), 0);

    // Ten back-to-back reads with three bytes arriving underneath
    pulse_sof();
    chk("t3_fv_kept", 32'(frame_valid), 1);
    r0 = rq.size();
    w0 = wq.size();
    t0 = cyc_n;
    for (int i = 0; i < 10; i++) begin
      rd_req  = 1'b1;
      rd_addr = 15'(100 + i);
      wr_req  = (i < 3);
      wr_data = 8'(8'hC1 + i);
      step();
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    step(8);
    chk("t3_rd_cnt", rq.size() - r0, 10);
    for (int i = 0; i < 10; i++) begin
      if (r0 + i < rq.size()) begin
        a = 15'(100 + i);
        chk("t3_rd_cyc", rq[r0 + i].cyc, t0 + 2 + i);
        chk("t3_rd_data", 32'(rq[r0 + i].data), 32'(a[7:0] ^ 8'hA5));
      end
    end
    chk("t3_wr_cnt", wq.size() - w0, 3);
    for (int i = 0; i < 3; i++) begin
      chk_wr("t3_wr", w0 + i, 15'(i), 8'(8'hC1 + i), t0 + 11 + i);
    end

    // Reads starve writes: two of six bytes dropped, four drain afterwards
    pulse_sof();
    w0      = wq.size();
    rd_req  = 1'b1;
    rd_addr = 15'd5;
    for (int i = 0; i < 6; i++) begin
      wr_req  = 1'b1;
      wr_data = 8'(8'hD1 + i);
      step();
    end
    wr_req = 1'b0;
    step(2);
    chk("t4_starved", wq.size() - w0, 0);
    chk("t4_ovf", 32'(wr_ovf), 1);
`ifdef FB_ARB_STATS_EN
    chk("t4_drop_cnt", 32'(drop_cnt), 2);
    chk("t4_max_fill", 32'(max_fill), 4);
`endif
    rd_req = 1'b0;
    step(8);
    chk("t4_wr_cnt", wq.size() - w0, 4);
    for (int i = 0; i < 4; i++) begin
      chk_wr("t4_wr", w0 + i, 15'(i), 8'(8'hD1 + i), -1);
    end

    // Frame restart at wr_addr 57 with two queued bytes and a coincident byte
    pulse_sof();
    for (int i = 0; i < 57; i++) begin
      wr_req  = 1'b1;
      wr_data = 8'(i);
      step();
    end
    wr_req = 1'b0;
    step(4);
    chk_wr("t5_pre", wq.size() - 1, 15'd56, 8'd56, -1);
    w0      = wq.size();
    rd_req  = 1'b1;
    rd_addr = 15'd0;
    wr_req  = 1'b1;
    wr_data = 8'hE1;
    step();
    wr_data = 8'hE2;
    step();
    wr_req  = 1'b0;
    step();
    sof_clr = 1'b1;
    wr_req  = 1'b1;
    wr_data = 8'hAB;
    t0      = cyc_n;
    step();
    sof_clr = 1'b0;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    step(6);
    chk("t5_wr_cnt", wq.size() - w0, 1);
    chk_wr("t5_wr", w0, 15'd0, 8'hAB, t0 + 2);
    chk("t5_ovf_kept", 32'(wr_ovf), 1);
    chk("t5_fv_kept", 32'(frame_valid), 1);
`ifdef FB_ARB_STATS_EN
    chk("t5_drop_clr", 32'(drop_cnt), 0);
    chk("t5_max_kept", 32'(max_fill), 4);
`endif

    // Asynchronous reset while a read is in flight
    for (int i = 0; i < 3; i++) begin
      wr_req  = 1'b1;
      wr_data = 8'(8'h50 + i);
      step();
    end
    wr_req = 1'b0;
    step(4);
    rd_req  = 1'b1;
    rd_addr = 15'd200;
    step();
    rd_req  = 1'b0;
    chk("t6_rd_inflight", 32'(ram_en), 1);
    r0      = rq.size();
    sys_rst = 1'b1;
    #1;
    chk("t6_ram_en", 32'(ram_en), 0);
    chk("t6_ram_addr", 32'(ram_addr), 0);
    chk("t6_ram_wdata", 32'(ram_wdata), 0);
    chk("t6_rd_valid", 32'(rd_valid), 0);
    chk("t6_rd_data", 32'(rd_data), 0);
    chk("t6_fv", 32'(frame_valid), 0);
    chk("t6_ovf", 32'(wr_ovf), 0);
    step(2);
    sys_rst = 1'b0;
    step(5);
    chk("t6_no_rd_valid", rq.size() - r0, 0);
`ifdef FB_ARB_STATS_EN
    chk("t6_max_fill", 32'(max_fill), 0);
`endif
    w0      = wq.size();
    wr_req  = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_req  = 1'b0;
    step(4);
    chk_wr("t6_wr", w0, 15'd0, 8'h3C, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buf_arbiter.md
# frame_buf_arbiter

Arbiter and write sequencer for the single-port frame buffer in the edge-detection design. It accepts pixel bytes from the UART receiver and assigns them consecutive frame addresses. It shares the one RAM port between this write stream and the VGA/edge-filter read stream. Reads have absolute priority, and writes are buffered in a small FIFO.

## Interface
Parameters:
- IMG_W, 180, image width in pixels
- IMG_H, 180, image height in pixels
- ADDR_W, 15, RAM address width (must satisfy 2^ADDR_W ≥ IMG_W·IMG_H)
- DATA_W, 8, pixel width
- WFIFO_DEPTH, 4, write FIFO depth (power of 2, ≥2)

Ports:
- board_clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- wr_req  in  1  one-cycle pulse: wr_data holds a received byte
- wr_data  in  DATA_W  received pixel byte
- sof_clr  in  1  one-cycle pulse: restart frame at address 0 and flush the FIFO
- rd_req  in  1  read request, may be held high for consecutive reads
- rd_addr  in  ADDR_W  read address
- rd_valid  out  1  rd_data is valid
- rd_data  out  DATA_W  read pixel
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_en
- frame_done  out  1  one-cycle pulse on the write of the last pixel
- frame_valid  out  1  sticky: at least one full frame has been stored
- wr_ovf  out  1  sticky: a byte was dropped

## Operation
- Write FIFO: a push occurs on wr_req. A pop occurs when a write slot is granted.
- Each cycle, the arbiter makes one decision:
  - rd_req=1: issue a read. Writes wait.
  - otherwise, if the FIFO is non-empty: pop and issue a write at wr_addr, then increment wr_addr.
  - otherwise: idle.
- wr_addr counts 0 to IMG_W·IMG_H−1, then wraps to 0.
- The write to the last address:
  - pulses frame_done one cycle later, aligned with that ram_we.
  - sets frame_valid.
- FIFO full, with wr_req and no pop in the same cycle: the byte is dropped, wr_ovf is set, and wr_addr does not advance.
- FIFO full, with wr_req and a pop in the same cycle: the push is accepted.
- sof_clr:
  - Next cycle: FIFO empty, wr_addr=0.
  - frame_valid and wr_ovf are unchanged.
  - An in-flight RAM write completes.
  - wr_req in the same cycle: the byte is accepted as pixel 0 of the new frame.
  - A pop in the same cycle is discarded.
- Reset values: all outputs 0, FIFO empty, wr_addr=0. Reset mid-frame abandons the frame.

## Timing
- Arbitration decision in cycle N. ram_en, ram_we, ram_addr and ram_wdata are registered and appear in cycle N+1.
- Read latency: rd_req at N gives rd_valid/rd_data at N+2 (RAM read in N+1, data captured into rd_data at N+2). rd_valid is high for exactly one cycle per request.
- Back-to-back reads sustain one read per cycle.
- Write latency: wr_req at N, with the FIFO empty and rd_req low at N+1, gives ram_we at N+2.
- ram_en=0 on idle cycles. ram_we=1 only on write cycles.
- Continuous rd_req starves writes. Drops are then reported through wr_ovf.

## Configuration
- FB_ARB_STATS_EN defined:
  - adds output drop_cnt [15:0], which counts dropped bytes, saturates at 16'hFFFF, resets to 0 and is cleared by sof_clr.
  - adds output max_fill [$clog2(WFIFO_DEPTH):0], the FIFO high-water mark, which resets to 0.
- Undefined: neither port nor any counter logic exists.

## Structure
- Shared package fb_pkg holds:
  - IMG_W/IMG_H defaults.
  - the FRAME_PIX = IMG_W·IMG_H constant.
  - the arbiter grant enum {GNT_IDLE, GNT_RD, GNT_WR}.
- One sub-module, fb_wfifo, implements the synchronous FIFO with push, pop, dout, count, full and empty, cleared by flush.

## Test plan
- Reset, then 5 wr_req bytes 0x11..0x15 spaced 4 cycles, rd_req low → ram_we at addresses 0..4 with data 0x11..0x15, each 2 cycles after its wr_req.
- After 32400 writes (IMG 180×180) → frame_done one pulse on the address-32399 write, frame_valid=1. The next byte is written to address 0.
- rd_req high for 10 cycles with addresses 100..109 during 3 pushed bytes → 10 reads issued first, rd_valid 10 consecutive cycles from N+2 with matching data, then 3 writes.
- rd_req held high, 6 wr_req pulses, WFIFO_DEPTH=4 → bytes 5 and 6 dropped, wr_ovf=1, and with FB_ARB_STATS_EN drop_cnt=2, max_fill=4. After release, the 4 stored bytes go to consecutive addresses.
- sof_clr coincident with wr_req 0xAB at wr_addr=57 with 2 bytes queued → queued bytes discarded, 0xAB written to address 0.
- sys_rst asserted mid-frame, while a read is pending → all outputs 0 immediately, and no rd_valid for the pending read after release.
